// File: rtl/base10_alu_sequencer.sv
// Command-side initiator for one base-10 ALU: issues one valid/ready command at a time,
// drives the level-enable ALU protocol with timeout, and returns a tagged response.
module base10_alu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_tag,
  output logic             alu_enable,
  output logic [3:0]       alu_operation,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_tag,
  output logic             rsp_error,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_LAST = 4'd8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic              r_cmd_ready;
  logic              r_alu_enable;
  logic [3:0]        r_alu_operation;
  logic [31:0]       r_alu_operand_a;
  logic [31:0]       r_alu_operand_b;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_result;
  logic [3:0]        r_rsp_tag;
  logic              r_rsp_error;
  logic              r_busy;
  logic [CNT_W-1:0]  r_op_count;
  logic [CNT_W-1:0]  r_timeout_count;

  logic w_div_by_zero;
  assign w_div_by_zero = (r_alu_operation == OP_DIV) && (r_alu_operand_b == 32'd0);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_cmd_ready     <= 1'b1;
      r_alu_enable    <= 1'b0;
      r_alu_operation <= '0;
      r_alu_operand_a <= '0;
      r_alu_operand_b <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_result    <= '0;
      r_rsp_tag       <= '0;
      r_rsp_error     <= 1'b0;
      r_busy          <= 1'b0;
      r_op_count      <= '0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_alu_operation <= cmd_op;
            r_alu_operand_a <= cmd_a;
            r_alu_operand_b <= cmd_b;
            r_rsp_tag       <= cmd_tag;
            r_cmd_ready     <= 1'b0;
            r_busy          <= 1'b1;
            if (cmd_op <= OP_LAST) begin
              r_timer      <= '0;
              r_alu_enable <= 1'b1;
              r_state      <= S_ISSUE;
            end else begin
              r_rsp_result <= '0;
              r_rsp_error  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end

        // A done on the final timeout cycle takes priority over the abort.
        S_ISSUE: begin
          if (alu_done) begin
            r_rsp_result <= alu_result;
            r_rsp_error  <= w_div_by_zero;
            r_alu_enable <= 1'b0;
            r_state      <= S_RELEASE;
          end else if (r_timer == TMR_LAST) begin
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b1;
            r_alu_enable <= 1'b0;
            if (r_timeout_count != CNT_MAX) r_timeout_count <= r_timeout_count + CNT_W'(1);
            r_state      <= S_RELEASE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_RELEASE: begin
          r_state <= S_RESP;
        end

        S_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            if (r_op_count != CNT_MAX) r_op_count <= r_op_count + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign alu_enable    = r_alu_enable;
  assign alu_operation = r_alu_operation;
  assign alu_operand_a = r_alu_operand_a;
  assign alu_operand_b = r_alu_operand_b;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_tag       = r_rsp_tag;
  assign rsp_error     = r_rsp_error;
  assign busy          = r_busy;
  assign op_count      = r_op_count;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_base10_alu_sequencer.sv
// Bench for base10_alu_sequencer: behavioural ALU stub with programmable done latency,
// per-command reference of result/error/latency and saturating counter model.
module tb_base10_alu_sequencer;

  localparam int TO   = 15;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [31:0]   cmd_a;
  logic [31:0]   cmd_b;
  logic [3:0]    cmd_tag;
  logic          alu_enable;
  logic [3:0]    alu_operation;
  logic [31:0]   alu_operand_a;
  logic [31:0]   alu_operand_b;
  logic [31:0]   alu_result;
  logic          alu_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_result;
  logic [3:0]    rsp_tag;
  logic          rsp_error;
  logic          busy;
  logic [CW-1:0] op_count;
  logic [CW-1:0] timeout_count;

  int tests_run = 0;
  int failed    = 0;
  int op_cnt    = 0;
  int to_cnt    = 0;
  int alu_lat   = 1;
  int alu_cnt   = 0;

  base10_alu_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_error(rsp_error), .busy(busy),
    .op_count(op_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // ALU stub: done pulses once, alu_lat enabled cycles after enable rises.
  always @(posedge clk) begin
    #1;
    if (alu_enable) begin
      alu_cnt = alu_cnt + 1;
      if (alu_cnt == alu_lat) begin
        alu_done   = 1'b1;
        alu_result = alu_ref(alu_operation, alu_operand_a, alu_operand_b);
      end else begin
        alu_done   = 1'b0;
        alu_result = 32'hDEAD_BEEF;
      end
    end else begin
      alu_cnt  = 0;
      alu_done = 1'b0;
    end
  end

  task automatic do_cmd(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input int lat, input int hold);
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_n;
    bit          is_to;
    int          n;
    bit          en_seen;
    bit          bus_ok;
    is_to = 0;
    if (op > 4'd8) begin
      exp_res = 32'd0; exp_err = 1'b1; exp_n = 1;
    end else if (lat > TO) begin
      exp_res = 32'd0; exp_err = 1'b1; exp_n = TO + 2; is_to = 1;
    end else begin
      exp_res = alu_ref(op, a, b); exp_err = (op == 4'd3 && b == 32'd0); exp_n = lat + 2;
    end
    alu_lat = lat;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_tag = 4'($urandom);
    n = 0; en_seen = 0; bus_ok = 1;
    while (!rsp_valid && n < 100) begin
      if (alu_enable) begin
        en_seen = 1;
        if ({alu_operation, alu_operand_a, alu_operand_b} !== {op, a, b}) bus_ok = 0;
      end
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (n != exp_n) begin failed++; $display("FAIL %s latency: got %0d edges, expected %0d", nm, n, exp_n); end
    tests_run++;
    if (en_seen != (op <= 4'd8) || !bus_ok) begin
      failed++; $display("FAIL %s alu_bus: enable_seen=%0d bus_ok=%0d, expected enable_seen=%0d bus_ok=1", nm, en_seen, bus_ok, op <= 4'd8);
    end
    tests_run++;
    if ({rsp_result, rsp_tag, rsp_error} !== {exp_res, tag, exp_err}) begin
      failed++; $display("FAIL %s response: got res=%h tag=%0d err=%0d, expected res=%h tag=%0d err=%0d", nm, rsp_result, rsp_tag, rsp_error, exp_res, tag, exp_err);
    end
    tests_run++;
    if ({alu_enable, cmd_ready, busy} !== 3'b001) begin
      failed++; $display("FAIL %s resp_ctrl: got en/ready/busy=%b, expected 001", nm, {alu_enable, cmd_ready, busy});
    end
    if (is_to && to_cnt < CMAX) to_cnt++;
    tests_run++;
    if (timeout_count !== CW'(to_cnt)) begin
      failed++; $display("FAIL %s timeout_count: got %0d, expected %0d", nm, timeout_count, to_cnt);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({rsp_valid, cmd_ready, rsp_result, rsp_tag, rsp_error} !== {1'b1, 1'b0, exp_res, tag, exp_err}) begin
        failed++; $display("FAIL %s hold[%0d]: got valid=%0d ready=%0d res=%h, expected valid=1 ready=0 res=%h", nm, i, rsp_valid, cmd_ready, rsp_result, exp_res);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (op_cnt < CMAX) op_cnt++;
    tests_run++;
    if ({rsp_valid, cmd_ready, busy, op_count} !== {1'b0, 1'b1, 1'b0, CW'(op_cnt)}) begin
      failed++; $display("FAIL %s complete: got valid=%0d ready=%0d busy=%0d op_count=%0d, expected 0 1 0 %0d", nm, rsp_valid, cmd_ready, busy, op_count, op_cnt);
    end
    tests_run++;
    if ({alu_operation, alu_operand_a, alu_operand_b} !== {op, a, b}) begin
      failed++; $display("FAIL %s alu_hold_last: got op=%0d a=%h b=%h, expected op=%0d a=%h b=%h", nm, alu_operation, alu_operand_a, alu_operand_b, op, a, b);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b0;
    alu_done = 1'b0; alu_result = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({cmd_ready, alu_enable, rsp_valid, rsp_error, busy, op_count, timeout_count, rsp_result, rsp_tag, alu_operation, alu_operand_a, alu_operand_b} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0), CW'(0), 32'd0, 4'd0, 4'd0, 32'd0, 32'd0}) begin
      failed++; $display("FAIL reset_values: got ready=%0d en=%0d valid=%0d err=%0d busy=%0d opc=%0d toc=%0d res=%h", cmd_ready, alu_enable, rsp_valid, rsp_error, busy, op_count, timeout_count, rsp_result);
    end
    reset = 1'b0;
    op_cnt = 0; to_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    do_cmd("add", 4'd0, 32'd123, 32'd877, 4'd5, 3, 0);
    do_cmd("div_zero", 4'd3, 32'd1000, 32'd0, 4'd1, 2, 0);
    do_cmd("div", 4'd3, 32'd1000, 32'd10, 4'd2, 4, 0);
    do_cmd("illegal", 4'd12, 32'h1234, 32'h5678, 4'd9, 3, 0);
    do_cmd("timeout", 4'd0, 32'd1, 32'd2, 4'd3, 10000, 0);
    do_cmd("done_last", 4'd4, 32'hF0F0, 32'hFF00, 4'd4, TO, 0);
    do_cmd("done_late", 4'd5, 32'hF0F0, 32'hFF00, 4'd6, TO + 1, 0);
    do_cmd("mul_bp", 4'd2, 32'd25, 32'd4, 4'd7, 1, 10);
  endtask

  task automatic test_reset_mid;
    alu_lat = 10000;
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 32'd9; cmd_b = 32'd4; cmd_tag = 4'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({alu_enable, cmd_ready, busy, rsp_valid, op_count, timeout_count} !== {1'b0, 1'b1, 1'b0, 1'b0, CW'(0), CW'(0)}) begin
      failed++; $display("FAIL reset_mid: got en=%0d ready=%0d busy=%0d valid=%0d opc=%0d toc=%0d, expected 0 1 0 0 0 0", alu_enable, cmd_ready, busy, rsp_valid, op_count, timeout_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    op_cnt = 0; to_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      tests_run++;
      if ({rsp_valid, alu_enable, cmd_ready} !== 3'b001) begin
        failed++; $display("FAIL reset_mid_quiet: got valid/en/ready=%b, expected 001", {rsp_valid, alu_enable, cmd_ready});
      end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < CMAX + 2; i++) do_cmd("sat_timeout", 4'd6, $urandom, $urandom, 4'(i), 10000, 0);
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 10));
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      do_cmd("random", op, $urandom, b, 4'($urandom), $urandom_range(1, TO + 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_reset_mid;
    test_saturation;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
